mips_trace_fifo: RTL and testbench

//  Downstream observer of mips_processor. Samples pc_out/alu_result each clock
//  and records a (pc, alu) entry whenever PC changes. Entries are buffered in a

---
 rtl/mips_trace_pkg.sv | 17 +
 rtl/mips_sync_fifo.sv | 66 ++++++
 rtl/mips_trace_fifo.sv | 84 ++++++++
 tb/tb_mips_trace_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared types and defaults for the MIPS trace capture path.
// Entry layout is {pc, alu}; the FIFO stores it as one flat word.
package mips_trace_pkg;

  localparam int TRACE_PC_WIDTH   = 16;
  localparam int TRACE_DATA_WIDTH = 16;
  localparam int TRACE_DEPTH      = 16;
  localparam int TRACE_OVF_WIDTH  = 8;

  typedef struct packed {
    logic [TRACE_PC_WIDTH-1:0]   pc;
    logic [TRACE_DATA_WIDTH-1:0] alu;
  } trace_entry_t;

  localparam int TRACE_ENTRY_WIDTH = $bits(trace_entry_t);

endpackage

// File: rtl/mips_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy count.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module mips_sync_fifo
  import mips_trace_pkg::*;
#(
  parameter int WIDTH = TRACE_ENTRY_WIDTH,
  parameter int DEPTH = TRACE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is forced to zero while empty so nothing stale leaks out after reset.
  assign dout  = (count_q == '0) ? '0 : mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/mips_trace_fifo.sv
// Passive PC-change tracer: records (pc, alu) whenever the CPU PC changes,
// buffers entries in a FIFO and counts (never stalls on) overflow.
module mips_trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int PC_WIDTH   = TRACE_PC_WIDTH,
  parameter int DATA_WIDTH = TRACE_DATA_WIDTH,
  parameter int DEPTH      = TRACE_DEPTH,
  parameter int OVF_WIDTH  = TRACE_OVF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    capture_en,
  input  logic [PC_WIDTH-1:0]     pc_in,
  input  logic [DATA_WIDTH-1:0]   alu_in,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [PC_WIDTH-1:0]     trace_pc,
  output logic [DATA_WIDTH-1:0]   trace_alu,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic [OVF_WIDTH-1:0]    overflow_cnt
);

  localparam int EW = PC_WIDTH + DATA_WIDTH;

  logic [PC_WIDTH-1:0] last_pc;
  logic                first;
  logic                capture;
  logic                push;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [EW-1:0]       head;

  // Stream handshake: an entry transfers on the rising edge where
  // trace_valid && trace_ready; the head stays stable while valid && !ready,
  // and trace_ready has no effect while the FIFO is empty.
  assign capture = capture_en && (first || (pc_in != last_pc));
  assign pop     = trace_valid && trace_ready;
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  // The PC is remembered even when its entry is dropped, so a stalled CPU
  // does not refill the FIFO with the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc <= '0;
      first   <= 1'b1;
    end else if (capture) begin
      last_pc <= pc_in;
      first   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != '1)) begin
      overflow_cnt <= overflow_cnt + OVF_WIDTH'(1);
    end
  end

  mips_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({pc_in, alu_in}),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {trace_pc, trace_alu} = head;
  assign trace_valid           = !fifo_empty;
  assign full                  = fifo_full;

endmodule

// File: tb/tb_mips_trace_fifo.sv
// Directed bench for mips_trace_fifo with a queue-based reference model.
// A second instance (DEPTH=2, OVF_WIDTH=2) exercises counter saturation.
module tb_mips_trace_fifo;

  logic        clk;
  logic        rst_n;
  logic        capture_en;
  logic [15:0] pc_in;
  logic [15:0] alu_in;
  logic        trace_valid;
  logic        trace_ready;
  logic [15:0] trace_pc;
  logic [15:0] trace_alu;
  logic [4:0]  count;
  logic        full;
  logic [7:0]  overflow_cnt;

  logic        cap2;
  logic [15:0] pc2;
  logic [15:0] alu2;
  logic        rdy2;
  logic        tv2;
  logic [15:0] tp2;
  logic [15:0] ta2;
  logic [1:0]  cnt2;
  logic        full2;
  logic [1:0]  ovf2;

  int vectors;
  int miscompares;

  logic [31:0] exp_q[$];
  logic        m_first;
  logic [15:0] m_last;
  int          m_ovf;

  mips_trace_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_en   (capture_en),
    .pc_in        (pc_in),
    .alu_in       (alu_in),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_alu    (trace_alu),
    .count        (count),
    .full         (full),
    .overflow_cnt (overflow_cnt)
  );

  mips_trace_fifo #(
    .PC_WIDTH   (16),
    .DATA_WIDTH (16),
    .DEPTH      (2),
    .OVF_WIDTH  (2)
  ) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_en   (cap2),
    .pc_in        (pc2),
    .alu_in       (alu2),
    .trace_valid  (tv2),
    .trace_ready  (rdy2),
    .trace_pc     (tp2),
    .trace_alu    (ta2),
    .count        (cnt2),
    .full         (full2),
    .overflow_cnt (ovf2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", {31'd0, trace_valid}, {31'd0, exp_q.size() != 0});
    chk("count", {27'd0, count}, exp_q.size());
    chk("full", {31'd0, full}, {31'd0, exp_q.size() == 16});
    chk("overflow_cnt", {24'd0, overflow_cnt}, m_ovf);
    if (exp_q.size() != 0) chk("head", {trace_pc, trace_alu}, exp_q[0]);
    else                   chk("head_idle", {trace_pc, trace_alu}, 32'd0);
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic drive(input logic cen, input logic [15:0] pc, input logic [15:0] alu,
                       input logic rdy);
    logic cap;
    logic mpop;
    logic mfull;
    capture_en  = cen;
    pc_in       = pc;
    alu_in      = alu;
    trace_ready = rdy;
    check_model();
    cap   = cen && (m_first || (pc != m_last));
    mpop  = (exp_q.size() != 0) && rdy;
    mfull = (exp_q.size() == 16);
    if (mpop) void'(exp_q.pop_front());
    if (cap) begin
      m_first = 1'b0;
      m_last  = pc;
      if (mfull && !mpop) begin
        if (m_ovf < 255) m_ovf++;
      end else begin
        exp_q.push_back({pc, alu});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    capture_en  = 1'b0;
    trace_ready = 1'b0;
    cap2        = 1'b0;
    #1;
    chk("rst_valid", {31'd0, trace_valid}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
    chk("rst_head", {trace_pc, trace_alu}, 32'd0);
    chk("rst_ovf2", {30'd0, ovf2}, 32'd0);
    exp_q.delete();
    m_first = 1'b1;
    m_last  = '0;
    m_ovf   = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] pcs2 [5];
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    capture_en  = 1'b0;
    pc_in       = '0;
    alu_in      = '0;
    trace_ready = 1'b0;
    cap2        = 1'b0;
    pc2         = '0;
    alu2        = '0;
    rdy2        = 1'b0;
    m_first     = 1'b1;
    m_last      = '0;
    m_ovf       = 0;
    @(negedge clk);
    do_reset();

    // reset mid-stream with 5 entries held
    for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i * 2), 16'(i), 1'b0);
    chk("t1_count5", {27'd0, count}, 32'd5);
    do_reset();
    drive(1'b1, 16'h0000, 16'h0055, 1'b0);
    chk("t1_first_count", {27'd0, count}, 32'd1);
    chk("t1_first_head", {trace_pc, trace_alu}, 32'h0000_0055);

    // change detect: pc 0,0,2,2,4
    do_reset();
    pcs2 = '{16'h0, 16'h0, 16'h2, 16'h2, 16'h4};
    for (int i = 0; i < 5; i++) drive(1'b1, pcs2[i], 16'hA000 + 16'(i), 1'b0);
    chk("t2_count", {27'd0, count}, 32'd3);
    chk("t2_head0", {trace_pc, trace_alu}, 32'h0000_A000);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    chk("t2_head1", {trace_pc, trace_alu}, 32'h0002_A002);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    chk("t2_head2", {trace_pc, trace_alu}, 32'h0004_A004);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    chk("t2_empty", {31'd0, trace_valid}, 32'd0);

    // overflow: 20 distinct pcs, sink stalled
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 16'(i * 4), 16'(i), 1'b0);
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_count", {27'd0, count}, 32'd16);
    chk("t3_ovf", {24'd0, overflow_cnt}, 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_pc", {16'd0, trace_pc}, i * 4);
      drive(1'b0, 16'h0, 16'h0, 1'b1);
    end
    chk("t3_drained", {27'd0, count}, 32'd0);

    // push+pop while full
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 16'(i * 4), 16'(i), 1'b0);
    drive(1'b1, 16'h0040, 16'h0040, 1'b1);
    chk("t4_count", {27'd0, count}, 32'd16);
    chk("t4_ovf", {24'd0, overflow_cnt}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain_pc", {16'd0, trace_pc}, (i + 1) * 4);
      drive(1'b0, 16'h0, 16'h0, 1'b1);
    end

    // push+pop at count==1: no bubble
    do_reset();
    drive(1'b1, 16'h0008, 16'h0011, 1'b0);
    drive(1'b1, 16'h000C, 16'h0022, 1'b1);
    chk("t4b_count", {27'd0, count}, 32'd1);
    chk("t4b_head", {trace_pc, trace_alu}, 32'h000C_0022);
    drive(1'b0, 16'h0, 16'h0, 1'b1);

    // capture_en low keeps last_pc
    do_reset();
    drive(1'b1, 16'h0100, 16'h0001, 1'b0);
    drive(1'b0, 16'h0200, 16'h0002, 1'b0);
    drive(1'b1, 16'h0100, 16'h0003, 1'b0);
    chk("t7_no_recapture", {27'd0, count}, 32'd1);
    drive(1'b1, 16'h0200, 16'h0004, 1'b0);
    chk("t7_change", {27'd0, count}, 32'd2);

    // random back-pressure against the model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom_range(0, 7) * 2),
            16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 18; i++) drive(1'b0, 16'h0, 16'h0, 1'b1);
    chk("t5_drained", {27'd0, count}, 32'd0);

    // saturation on the narrow-counter instance
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cap2 = 1'b1;
      pc2  = 16'(i);
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      if (i == 4) begin
        chk("t6_cnt2", {30'd0, cnt2}, 32'd2);
        chk("t6_full2", {31'd0, full2}, 32'd1);
        chk("t6_ovf2_2", {30'd0, ovf2}, 32'd2);
      end
      if (i == 8) chk("t6_ovf2_sat", {30'd0, ovf2}, 32'd3);
    end
    cap2 = 1'b0;
    chk("t6_ovf2_hold", {30'd0, ovf2}, 32'd3);
    chk("t6_head2", {tp2, ta2}, 32'h0001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
